// File: rtl/alu_share_if.sv
// Request/response and ALU-side bundle between requesters, the share arbiter and the ALU.
// slave = arbiter side, master = requesters plus ALU (testbench side).
interface alu_share_if #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*3-1:0]     req_op;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [2*WIDTH-1:0]       rsp_result;
    logic                     rsp_err;
    logic [WIDTH-1:0]         alu_a;
    logic [WIDTH-1:0]         alu_b;
    logic [2:0]               alu_op;
    logic [2*WIDTH-1:0]       alu_result;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, alu_a, alu_b, alu_op
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one registered add/sub/mul/div ALU among NUM_REQ requesters,
// with divide-by-zero and illegal-op requests answered directly as errors.
module alu_share_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_share_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t                       state, state_nxt;
    logic [IDW-1:0]               rr_ptr, lat_id, gnt_id, idx;
    logic                         gnt_found, bad_req, rsp_done;
    logic [NUM_REQ-1:0][WIDTH-1:0] a_v, b_v;
    logic [NUM_REQ-1:0][2:0]      op_v;
    logic [WIDTH-1:0]             g_a, g_b;
    logic [2:0]                   g_op;

    assign a_v  = bus.req_a;
    assign b_v  = bus.req_b;
    assign op_v = bus.req_op;

    // Walk downward so the closest requester after rr_ptr is the last (winning) assignment.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    assign g_a      = a_v[gnt_id];
    assign g_b      = b_v[gnt_id];
    assign g_op     = op_v[gnt_id];
    assign bad_req  = g_op[2] | ((g_op == 3'b011) && (g_b == '0));
    assign rsp_done = (state == RESP) && bus.rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (gnt_found) state_nxt = bad_req ? RESP : EXEC;
            EXEC: state_nxt = CAPT;
            CAPT: state_nxt = RESP;
            RESP: if (rsp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && gnt_found) bus.req_ready[gnt_id] = 1'b1;
        bus.rsp_valid = (state == RESP);
    end

    // Datapath: operands latched into the ALU drivers at grant, result captured after one ALU cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr         <= IDW'(NUM_REQ - 1);
            lat_id         <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_op     <= 3'b111;
            bus.rsp_id     <= '0;
            bus.rsp_result <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt_found) begin
                    lat_id <= gnt_id;
                    if (bad_req) begin
                        bus.rsp_id     <= gnt_id;
                        bus.rsp_result <= '0;
                        bus.rsp_err    <= 1'b1;
                    end else begin
                        bus.alu_a  <= g_a;
                        bus.alu_b  <= g_b;
                        bus.alu_op <= g_op;
                    end
                end
                CAPT: begin
                    bus.rsp_result <= bus.alu_result;
                    bus.rsp_err    <= 1'b0;
                    bus.rsp_id     <= lat_id;
                    bus.alu_op     <= 3'b111;
                end
                RESP: if (rsp_done) rr_ptr <= lat_id;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural registered ALU on the ALU side.
module tb_alu_share_arbiter;
    localparam int WIDTH   = 4;
    localparam int NUM_REQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [NUM_REQ-1:0][WIDTH-1:0] a_v, b_v;
    logic [NUM_REQ-1:0][2:0]      op_v;

    alu_share_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

    alu_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.req_a  = a_v;
    assign bus.req_b  = b_v;
    assign bus.req_op = op_v;

    // Reference ALU: one-cycle registered result, 111 or unknown op yields zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.alu_result <= '0;
        else begin
            case (bus.alu_op)
                3'b000:  bus.alu_result <= {{WIDTH{1'b0}}, WIDTH'(bus.alu_a + bus.alu_b)};
                3'b001:  bus.alu_result <= {{WIDTH{1'b0}}, WIDTH'(bus.alu_a - bus.alu_b)};
                3'b010:  bus.alu_result <= {{WIDTH{1'b0}}, bus.alu_a} * {{WIDTH{1'b0}}, bus.alu_b};
                3'b011:  bus.alu_result <= (bus.alu_b == '0) ? '0 : {{WIDTH{1'b0}}, bus.alu_a / bus.alu_b};
                default: bus.alu_result <= '0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 0);
        chk({tag, "_rsp_result"}, 32'(bus.rsp_result), 0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
        chk({tag, "_alu_a"}, 32'(bus.alu_a), 0);
        chk({tag, "_alu_b"}, 32'(bus.alu_b), 0);
        chk({tag, "_alu_op"}, 32'(bus.alu_op), 32'h7);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        a_v  = '0;
        b_v  = '0;
        op_v = '0;

        // Reset values
        @(negedge clk); #1;
        chk_idle_outputs("reset");
        @(negedge clk); rst = 1'b0;

        // 1: single add on requester 0
        @(negedge clk);
        a_v[0] = 4'd3; b_v[0] = 4'd4; op_v[0] = 3'b000; bus.req_valid = 4'b0001; #1;
        chk("t1_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk); bus.req_valid = '0; #1;
        chk("t1_exec_valid", 32'(bus.rsp_valid), 0);
        chk("t1_exec_alu_a", 32'(bus.alu_a), 3);
        chk("t1_exec_alu_b", 32'(bus.alu_b), 4);
        chk("t1_exec_alu_op", 32'(bus.alu_op), 0);
        @(negedge clk); #1;
        chk("t1_capt_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk); #1;
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("t1_rsp_result", 32'(bus.rsp_result), 32'h07);
        chk("t1_rsp_id", 32'(bus.rsp_id), 0);
        chk("t1_rsp_err", 32'(bus.rsp_err), 0);
        @(negedge clk); #1;
        chk("t1_back_idle", 32'(bus.rsp_valid), 0);
        chk("t1_alu_op_park", 32'(bus.alu_op), 32'h7);

        // Fresh round-robin pointer for the rotation test
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // 2: all requesters valid, mul 15*15, strict rotation with 4-cycle spacing
        for (int i = 0; i < NUM_REQ; i++) begin
            a_v[i] = 4'd15; b_v[i] = 4'd15; op_v[i] = 3'b010;
        end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk); bus.req_valid = 4'b1111; #1;
            chk("t2_grant", 32'(bus.req_ready), 32'(4'b0001 << (n % 4)));
            @(negedge clk); #1;
            chk("t2_exec_ready", 32'(bus.req_ready), 0);
            chk("t2_exec_valid", 32'(bus.rsp_valid), 0);
            @(negedge clk); #1;
            chk("t2_capt_ready", 32'(bus.req_ready), 0);
            chk("t2_capt_valid", 32'(bus.rsp_valid), 0);
            @(negedge clk); #1;
            chk("t2_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("t2_rsp_result", 32'(bus.rsp_result), 32'hE1);
            chk("t2_rsp_id", 32'(bus.rsp_id), 32'(n % 4));
            chk("t2_rsp_err", 32'(bus.rsp_err), 0);
            if (n == 4) bus.req_valid = '0;
        end

        // 3: divide by zero on requester 2 answers next cycle without the ALU
        @(negedge clk);
        a_v[2] = 4'd9; b_v[2] = 4'd0; op_v[2] = 3'b011; bus.req_valid = 4'b0100; #1;
        chk("t3_grant", 32'(bus.req_ready), 32'h4);
        @(negedge clk); bus.req_valid = '0; #1;
        chk("t3_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("t3_rsp_err", 32'(bus.rsp_err), 1);
        chk("t3_rsp_result", 32'(bus.rsp_result), 0);
        chk("t3_rsp_id", 32'(bus.rsp_id), 2);
        chk("t3_alu_op", 32'(bus.alu_op), 32'h7);
        @(negedge clk); #1;
        chk("t3_back_idle", 32'(bus.rsp_valid), 0);

        // 4: illegal op on requester 1, then a wrapping subtract
        a_v[1] = 4'd1; b_v[1] = 4'd1; op_v[1] = 3'b101; bus.req_valid = 4'b0010; #1;
        chk("t4_ill_grant", 32'(bus.req_ready), 32'h2);
        @(negedge clk); bus.req_valid = '0; #1;
        chk("t4_ill_valid", 32'(bus.rsp_valid), 1);
        chk("t4_ill_err", 32'(bus.rsp_err), 1);
        chk("t4_ill_result", 32'(bus.rsp_result), 0);
        chk("t4_ill_id", 32'(bus.rsp_id), 1);
        @(negedge clk);
        a_v[1] = 4'd2; b_v[1] = 4'd5; op_v[1] = 3'b001; bus.req_valid = 4'b0010; #1;
        chk("t4_sub_grant", 32'(bus.req_ready), 32'h2);
        @(negedge clk); bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("t4_sub_valid", 32'(bus.rsp_valid), 1);
        chk("t4_sub_result", 32'(bus.rsp_result), 32'h0D);
        chk("t4_sub_err", 32'(bus.rsp_err), 0);
        chk("t4_sub_id", 32'(bus.rsp_id), 1);

        // 5: response back-pressure holds RESP, no grants while waiting
        @(negedge clk);
        a_v[0] = 4'd1; b_v[0] = 4'd2; op_v[0] = 3'b000; bus.req_valid = 4'b0001; bus.rsp_ready = 1'b0; #1;
        chk("t5_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk); bus.req_valid = 4'b0010;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk("t5_hold_valid", 32'(bus.rsp_valid), 1);
            chk("t5_hold_result", 32'(bus.rsp_result), 32'h03);
            chk("t5_hold_id", 32'(bus.rsp_id), 0);
            chk("t5_hold_err", 32'(bus.rsp_err), 0);
            chk("t5_hold_no_ready", 32'(bus.req_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("t5_release_valid", 32'(bus.rsp_valid), 0);
        chk("t5_next_grant", 32'(bus.req_ready), 32'h2);

        // 6: reset in EXEC drops the transaction and restores the pointer
        @(negedge clk); bus.req_valid = '0; #1;
        chk("t6_in_exec_op", 32'(bus.alu_op), 32'h1);
        rst = 1'b1; #1;
        chk_idle_outputs("t6_rst");
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("t6_no_rsp", 32'(bus.rsp_valid), 0);
        end
        bus.req_valid = 4'b0011; #1;
        chk("t6_first_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk); bus.req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
